// File: rtl/lever_event_pkg.sv
// Shared definitions for the lever event queue: register offsets, bit positions and entry layout.
package lever_event_pkg;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_RSVD   = 2'd3
  } reg_off_e;

  localparam int unsigned STAT_EMPTY_BIT   = 0;
  localparam int unsigned STAT_FULL_BIT    = 1;
  localparam int unsigned STAT_OVF_BIT     = 2;
  localparam int unsigned STAT_COUNT_LSB   = 8;

  localparam int unsigned CTRL_FLUSH_BIT   = 0;
  localparam int unsigned CTRL_CLR_OVF_BIT = 1;
  localparam int unsigned CTRL_CLR_TS_BIT  = 2;
  localparam int unsigned CTRL_MASK_LSB    = 8;

  localparam int unsigned ENTRY_CHG_LSB    = 0;
  localparam int unsigned ENTRY_SNAP_LSB   = 8;
  localparam int unsigned ENTRY_TS_LSB     = 16;
  localparam int unsigned ENTRY_W          = 32;

  function automatic logic [ENTRY_W-1:0] make_entry(input logic [15:0] ts,
                                                    input logic [7:0]  snap,
                                                    input logic [7:0]  chg);
    logic [ENTRY_W-1:0] e;
    e = '0;
    e[ENTRY_TS_LSB   +: 16] = ts;
    e[ENTRY_SNAP_LSB +: 8]  = snap;
    e[ENTRY_CHG_LSB  +: 8]  = chg;
    return e;
  endfunction

endpackage

// File: rtl/lever_event_fifo.sv
// First-word-fall-through FIFO for lever events; flush dominates push/pop.
module lever_event_fifo
  import lever_event_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign count   = count_q;
  assign head    = mem_q[rptr_q];
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/lever_event_queue.sv
// Memory-mapped lever change queue (DATA/STATUS/CTRL window at BASE_ADDR).
// Optional LEVER_EVENT_TIMESTAMP_EN adds a 16-bit cycle stamp in entry[31:16].
module lever_event_queue
  import lever_event_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_2000,
  parameter int unsigned DEPTH     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  levers,
  input  logic [31:0] memaddr,
  input  logic [31:0] memin,
  input  logic [3:0]  writeEnables,
  input  logic        memread,
  output logic        hit,
  output logic [31:0] memout
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]         prev_q;
  logic               primed_q;
  logic [7:0]         mask_q, mask_d;
  logic               ovf_q, ovf_d;
  reg_off_e           off;
  logic               ctrl_wr0, ctrl_wr1, flush, clr_ovf, pop;
  logic [7:0]         chg;
  logic               push_req, overflow;
  logic [ENTRY_W-1:0] entry, head;
  logic [AW:0]        count;
  logic               full, empty;
  logic [15:0]        ts;
  logic               unused_ok;

  assign hit      = (memaddr[31:4] == BASE_ADDR[31:4]);
  assign off      = reg_off_e'(memaddr[3:2]);
  assign ctrl_wr0 = hit && (off == REG_CTRL) && writeEnables[0];
  assign ctrl_wr1 = hit && (off == REG_CTRL) && writeEnables[1];
  assign flush    = ctrl_wr0 && memin[CTRL_FLUSH_BIT];
  assign clr_ovf  = ctrl_wr0 && memin[CTRL_CLR_OVF_BIT];
  assign pop      = hit && (off == REG_DATA) && memread;

  assign chg      = (levers ^ prev_q) & mask_q;
  assign push_req = primed_q && (chg != '0);
  // Full only overflows when no pop frees the head slot this cycle; flush swallows the push.
  assign overflow = push_req && !flush && full && !pop;

`ifdef LEVER_EVENT_TIMESTAMP_EN
  logic [15:0] ts_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    ts_q <= '0;
    else if (ctrl_wr0 && memin[CTRL_CLR_TS_BIT]) ts_q <= '0;
    else                                        ts_q <= ts_q + 16'd1;
  end
  assign ts        = ts_q;
  assign unused_ok = ^{memaddr[1:0], memin[31:16], memin[7:3], writeEnables[3:2]};
`else
  assign ts        = '0;
  assign unused_ok = ^{memaddr[1:0], memin[31:16], memin[7:3],
                       memin[CTRL_CLR_TS_BIT], writeEnables[3:2]};
`endif

  assign entry = make_entry(ts, levers, chg);

  always_comb begin
    mask_d = mask_q;
    if (ctrl_wr1) mask_d = memin[CTRL_MASK_LSB +: 8];
  end

  always_comb begin
    ovf_d = ovf_q;
    if (overflow)     ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q   <= '0;
      primed_q <= 1'b0;
      mask_q   <= '1;
      ovf_q    <= 1'b0;
    end else begin
      prev_q   <= levers;
      primed_q <= 1'b1;
      mask_q   <= mask_d;
      ovf_q    <= ovf_d;
    end
  end

  lever_event_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req && !flush),
    .din   (entry),
    .pop   (pop),
    .flush (flush),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    memout = '0;
    if (hit) begin
      case (off)
        REG_DATA: begin
          if (!empty) memout = head;
        end
        REG_STATUS: begin
          memout[STAT_COUNT_LSB +: 8] = 8'(count);
          memout[STAT_OVF_BIT]        = ovf_q;
          memout[STAT_FULL_BIT]       = full;
          memout[STAT_EMPTY_BIT]      = empty;
        end
        REG_CTRL: memout[CTRL_MASK_LSB +: 8] = mask_q;
        default:  memout = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_lever_event_queue.sv
// Scoreboard bench for lever_event_queue (default build, DEPTH=16).
module tb_lever_event_queue;

  localparam logic [31:0] BASE   = 32'h0000_2000;
  localparam logic [31:0] A_DATA = BASE;
  localparam logic [31:0] A_STAT = BASE + 32'd4;
  localparam logic [31:0] A_CTRL = BASE + 32'd8;
  localparam logic [31:0] A_RSVD = BASE + 32'd12;

  logic        clk;
  logic        rst;
  logic [7:0]  levers;
  logic [31:0] memaddr;
  logic [31:0] memin;
  logic [3:0]  writeEnables;
  logic        memread;
  logic        hit;
  logic [31:0] memout;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [31:0] mon_exp;
  string       mon_name;
  logic [7:0]  lv;

  lever_event_queue #(
    .BASE_ADDR (BASE),
    .DEPTH     (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .levers       (levers),
    .memaddr      (memaddr),
    .memin        (memin),
    .writeEnables (writeEnables),
    .memread      (memread),
    .hit          (hit),
    .memout       (memout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every read strobe is a DUT output to be checked against the scoreboard head.
  always @(negedge clk) begin
    if (memread) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read: got %08h, nothing expected", memout);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        if (memout !== mon_exp) begin
          errors++;
          $display("FAIL %s: got %08h expected %08h", mon_name, memout, mon_exp);
        end
      end
    end
  end

  task automatic rd(input logic [31:0] addr, input logic [31:0] e, input string n);
    memaddr = addr;
    memread = 1'b1;
    exp_q.push_back(e);
    name_q.push_back(n);
    @(posedge clk); #1;
    memread = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] d);
    memaddr      = addr;
    memin        = d;
    writeEnables = we;
    @(posedge clk); #1;
    writeEnables = '0;
  endtask

  task automatic lev(input logic [7:0] v);
    levers = v;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1; levers = 8'h05; memaddr = '0; memin = '0;
    writeEnables = '0; memread = 1'b0;
    idle(2);

    // Reset state and priming with levers already high
    rd(A_STAT, 32'h0000_0001, "reset_status");
    rd(A_CTRL, 32'h0000_FF00, "reset_ctrl");
    rst = 1'b0;
    idle(5);
    rd(A_STAT, 32'h0000_0001, "prime_status");
    rd(A_DATA, 32'h0000_0000, "prime_data");

    // Single changes, latency of one cycle, empty read returns 0
    lev(8'h00);
    rd(A_DATA, 32'h0000_0005, "fall_0_2");
    lev(8'h08);
    rd(A_DATA, 32'h0000_0808, "rise_3");
    rd(A_DATA, 32'h0000_0000, "empty_data");
    rd(A_STAT, 32'h0000_0001, "empty_status");

    // Mask
    wr(A_CTRL, 4'b0010, 32'h0000_0100);
    rd(A_CTRL, 32'h0000_0100, "mask_ctrl");
    lev(8'h0B);
    rd(A_STAT, 32'h0000_0100, "mask_count");
    rd(A_DATA, 32'h0000_0B01, "mask_entry");
    lev(8'h03);
    rd(A_STAT, 32'h0000_0001, "masked_nochange");

    // Overflow: 17 changes into 16 entries
    wr(A_CTRL, 4'b0010, 32'h0000_FF00);
    lv = 8'h03;
    for (int i = 0; i < 17; i++) begin
      lv = lv ^ 8'h80;
      lev(lv);
    end
    rd(A_STAT, 32'h0000_1006, "full_ovf");
    wr(A_CTRL, 4'b0001, 32'h0000_0002);
    rd(A_STAT, 32'h0000_1002, "ovf_clear");

    // Full FIFO: pop and change in the same cycle
    levers  = 8'h03;
    memaddr = A_DATA;
    memread = 1'b1;
    exp_q.push_back(32'h0000_8380);
    name_q.push_back("full_pop_head");
    @(posedge clk); #1;
    memread = 1'b0;
    rd(A_STAT, 32'h0000_1002, "full_pop_count");
    for (int j = 1; j < 16; j++) begin
      rd(A_DATA, (j % 2 == 1) ? 32'h0000_0380 : 32'h0000_8380, "drain");
    end
    rd(A_DATA, 32'h0000_0380, "new_tail");
    rd(A_STAT, 32'h0000_0001, "drained");

    // Flush in the same cycle as a change
    lev(8'h13);
    rd(A_STAT, 32'h0000_0100, "pre_flush");
    levers       = 8'h33;
    memaddr      = A_CTRL;
    memin        = 32'h0000_0001;
    writeEnables = 4'b0001;
    @(posedge clk); #1;
    writeEnables = '0;
    rd(A_STAT, 32'h0000_0001, "flush_status");
    lev(8'h32);
    rd(A_DATA, 32'h0000_3201, "post_flush_entry");

    // Reset mid-operation
    wr(A_CTRL, 4'b0010, 32'h0000_0F00);
    lev(8'h30);
    rd(A_STAT, 32'h0000_0100, "pre_reset_count");
    rst = 1'b1;
    rd(A_STAT, 32'h0000_0001, "midreset_status");
    rd(A_CTRL, 32'h0000_FF00, "midreset_ctrl");
    rst = 1'b0;
    idle(3);
    rd(A_STAT, 32'h0000_0001, "post_reset_prime");
    rd(A_RSVD, 32'h0000_0000, "reserved");
    rd(32'h0000_3000, 32'h0000_0000, "miss");

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_drain: %0d left, 0 required", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
